// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives active-low columns, samples synchronized rows,
// debounces whole scan passes and hands one key code at a time to a consumer.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ack_i,
  output logic       key_held_o,
  output logic       overrun_o
);

  localparam int DivW = $clog2(SCAN_DIV);
  localparam int CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] ScansMax = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam bit              OneScan  = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {
    Idle,
    Debounce,
    Pressed,
    Release
  } state_e;

  logic [3:0]      rowSync1_q, rowSync2_q;
  logic [DivW-1:0] divCnt_q, divCnt_d;
  logic [1:0]      colIdx_q, colIdx_d;
  logic [1:0]      snapCnt_q, snapCnt_d;
  logic [3:0]      snapCode_q, snapCode_d;
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] stable_q, stable_d;
  logic [CntW-1:0] rel_q, rel_d;
  logic [3:0]      code_q, code_d;
  logic            held_q, held_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic            sample, passEnd, accept;
  logic [1:0]      rowLowCnt, mergedCnt;
  logic [3:0]      rowLowCode, mergedCode;
  logic [2:0]      sumCnt;
  logic            candValid;

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rowSync1_q <= 4'hF;
      rowSync2_q <= 4'hF;
    end else begin
      rowSync1_q <= row_i;
      rowSync2_q <= rowSync1_q;
    end
  end

  assign sample  = (divCnt_q == DivLast);
  assign passEnd = sample && (colIdx_q == 2'd3);

  always_comb begin
    divCnt_d = divCnt_q + DivW'(1);
    colIdx_d = colIdx_q;
    if (sample) begin
      divCnt_d = '0;
      colIdx_d = colIdx_q + 2'd1;
    end
  end

  // Count low rows in this column (saturating at 2) and fold into the pass snapshot
  always_comb begin
    rowLowCnt  = 2'd0;
    rowLowCode = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!rowSync2_q[r]) begin
        if (rowLowCnt != 2'd2) rowLowCnt = rowLowCnt + 2'd1;
        rowLowCode = {2'(r), colIdx_q};
      end
    end
    sumCnt     = {1'b0, snapCnt_q} + {1'b0, rowLowCnt};
    mergedCnt  = (sumCnt >= 3'd2) ? 2'd2 : sumCnt[1:0];
    mergedCode = (rowLowCnt != 2'd0) ? rowLowCode : snapCode_q;
    candValid  = passEnd && (mergedCnt == 2'd1);
  end

  always_comb begin
    snapCnt_d  = snapCnt_q;
    snapCode_d = snapCode_q;
    if (passEnd) begin
      snapCnt_d  = 2'd0;
      snapCode_d = 4'd0;
    end else if (sample) begin
      snapCnt_d  = mergedCnt;
      snapCode_d = mergedCode;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divCnt_q   <= '0;
      colIdx_q   <= 2'd0;
      snapCnt_q  <= 2'd0;
      snapCode_q <= 4'd0;
    end else begin
      divCnt_q   <= divCnt_d;
      colIdx_q   <= colIdx_d;
      snapCnt_q  <= snapCnt_d;
      snapCode_q <= snapCode_d;
    end
  end

  // Debounce FSM; only moves at pass end, so the counters count whole passes
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    rel_d    = rel_q;
    code_d   = code_q;
    held_d   = held_q;
    accept   = 1'b0;
    if (passEnd) begin
      unique case (state_q)
        Idle: begin
          if (candValid) begin
            cand_d   = mergedCode;
            stable_d = CntOne;
            if (OneScan) begin
              state_d  = Pressed;
              stable_d = '0;
              code_d   = mergedCode;
              held_d   = 1'b1;
              accept   = 1'b1;
            end else begin
              state_d = Debounce;
            end
          end
        end
        Debounce: begin
          if (!candValid) begin
            state_d  = Idle;
            stable_d = '0;
          end else if (mergedCode == cand_q) begin
            stable_d = stable_q + CntOne;
            if (stable_q + CntOne >= ScansMax) begin
              state_d  = Pressed;
              stable_d = '0;
              code_d   = cand_q;
              held_d   = 1'b1;
              accept   = 1'b1;
            end
          end else begin
            cand_d   = mergedCode;
            stable_d = CntOne;
          end
        end
        Pressed: begin
          if (!candValid) begin
            rel_d = CntOne;
            if (OneScan) begin
              state_d = Idle;
              rel_d   = '0;
              held_d  = 1'b0;
            end else begin
              state_d = Release;
            end
          end
        end
        Release: begin
          if (candValid) begin
            state_d = Pressed;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + CntOne;
            if (rel_q + CntOne >= ScansMax) begin
              state_d = Idle;
              rel_d   = '0;
              held_d  = 1'b0;
            end
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  // An accept beats a simultaneous ack, and that ack does not count toward overrun
  always_comb begin
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      valid_d = 1'b1;
      if (valid_q && !key_ack_i) overrun_d = 1'b1;
      else if (key_ack_i)        overrun_d = 1'b0;
    end else if (key_ack_i && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      cand_q    <= 4'd0;
      stable_q  <= '0;
      rel_q     <= '0;
      code_q    <= 4'd0;
      held_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      held_q    <= held_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign col_o       = ~(4'b0001 << colIdx_q);
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_held_o  = held_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls rows low for pressed keys
// whose column is driven, with scan timing SCAN_DIV=4, DEBOUNCE_SCANS=2.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyAck;
  logic        keyHeld;
  logic        overrun;
  logic [15:0] keysDown;

  int checks;
  int failures;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .row_i(row),
    .col_o(col),
    .key_code_o(keyCode),
    .key_valid_o(keyValid),
    .key_ack_i(keyAck),
    .key_held_o(keyHeld),
    .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keysDown[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle of a scan pass (column 0, div 0)
  task automatic alignPass();
    int n;
    n = 0;
    while (col !== 4'b0111 && n < 40) begin step(1); n++; end
    while (col !== 4'b1110 && n < 40) begin step(1); n++; end
    checks++;
    if (col !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL align_pass: col=%b expected 1110", col);
    end
  endtask

  task automatic ackPulse();
    keyAck = 1'b1;
    step(1);
    keyAck = 1'b0;
  endtask

  task automatic waitHeldLow(input string name);
    int n;
    n = 0;
    while (keyHeld !== 1'b0 && n < 60) begin step(1); n++; end
    checks++;
    if (keyHeld !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s: key_held=%b expected 0 within 60 cycles", name, keyHeld);
    end
  endtask

  task automatic waitValidHigh(input string name);
    int n;
    n = 0;
    while (keyValid !== 1'b1 && n < 50) begin step(1); n++; end
    checks++;
    if (keyValid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s: key_valid=%b expected 1 within 50 cycles", name, keyValid);
    end
  endtask

  task automatic test_reset();
    logic [3:0] colTable [4];
    colTable[0] = 4'b1110;
    colTable[1] = 4'b1101;
    colTable[2] = 4'b1011;
    colTable[3] = 4'b0111;
    rst_n = 1'b0;
    step(3);
    checks += 5;
    if (col !== 4'b1110) begin failures++; $display("[TB] FAIL reset_col: col=%b expected 1110", col); end
    if (keyCode !== 4'd0) begin failures++; $display("[TB] FAIL reset_code: key_code=%0d expected 0", keyCode); end
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: key_valid=%b expected 0", keyValid); end
    if (keyHeld !== 1'b0) begin failures++; $display("[TB] FAIL reset_held: key_held=%b expected 0", keyHeld); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: overrun=%b expected 0", overrun); end
    rst_n = 1'b1;
    checks++;
    if (col !== 4'b1110) begin failures++; $display("[TB] FAIL scan_cycle0: col=%b expected 1110", col); end
    for (int i = 1; i <= 16; i++) begin
      step(1);
      checks++;
      if (col !== colTable[(i/4)%4]) begin
        failures++;
        $display("[TB] FAIL scan_cycle%0d: col=%b expected %b", i, col, colTable[(i/4)%4]);
      end
    end
  endtask

  task automatic test_single_press();
    alignPass();
    keysDown[6] = 1'b1;
    waitValidHigh("single_valid");
    checks += 3;
    if (keyCode !== 4'd6) begin failures++; $display("[TB] FAIL single_code: key_code=%0d expected 6", keyCode); end
    if (keyHeld !== 1'b1) begin failures++; $display("[TB] FAIL single_held: key_held=%b expected 1", keyHeld); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL single_overrun: overrun=%b expected 0", overrun); end
    ackPulse();
    checks += 2;
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_valid: key_valid=%b expected 0", keyValid); end
    if (keyCode !== 4'd6) begin failures++; $display("[TB] FAIL single_ack_code: key_code=%0d expected 6", keyCode); end
    step(25);
    keysDown[6] = 1'b0;
    step(10);
    checks++;
    if (keyHeld !== 1'b1) begin failures++; $display("[TB] FAIL single_held_early: key_held=%b expected 1", keyHeld); end
    waitHeldLow("single_release");
    checks++;
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL single_release_valid: key_valid=%b expected 0", keyValid); end
  endtask

  task automatic test_bounce();
    logic sawValid, sawHeld;
    sawValid = 1'b0;
    sawHeld  = 1'b0;
    alignPass();
    for (int c = 0; c < 80; c++) begin
      keysDown[6] = (c >= 2) && (c < 42) && ((((c - 2) / 5) % 2) == 0);
      sawValid |= keyValid;
      sawHeld  |= keyHeld;
      step(1);
    end
    keysDown[6] = 1'b0;
    checks += 2;
    if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL bounce_valid: key_valid seen=%b expected 0", sawValid); end
    if (sawHeld !== 1'b0) begin failures++; $display("[TB] FAIL bounce_held: key_held seen=%b expected 0", sawHeld); end
  endtask

  task automatic test_ghost();
    logic sawValid;
    sawValid = 1'b0;
    alignPass();
    keysDown[0]  = 1'b1;
    keysDown[11] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      sawValid |= keyValid;
      step(1);
    end
    checks++;
    if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL ghost_valid: key_valid seen=%b expected 0", sawValid); end
    keysDown[11] = 1'b0;
    waitValidHigh("ghost_single_valid");
    checks += 2;
    if (keyCode !== 4'd0) begin failures++; $display("[TB] FAIL ghost_code: key_code=%0d expected 0", keyCode); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ghost_overrun: overrun=%b expected 0", overrun); end
    keysDown[0] = 1'b0;
    waitHeldLow("ghost_release");
    ackPulse();
  endtask

  task automatic test_overrun();
    alignPass();
    keysDown[5] = 1'b1;
    waitValidHigh("overrun_first_valid");
    checks += 2;
    if (keyCode !== 4'd5) begin failures++; $display("[TB] FAIL overrun_first_code: key_code=%0d expected 5", keyCode); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_first_flag: overrun=%b expected 0", overrun); end
    keysDown[5] = 1'b0;
    waitHeldLow("overrun_first_release");
    keysDown[9] = 1'b1;
    begin
      int n;
      n = 0;
      while (keyHeld !== 1'b1 && n < 60) begin step(1); n++; end
    end
    checks += 4;
    if (keyHeld !== 1'b1) begin failures++; $display("[TB] FAIL overrun_second_held: key_held=%b expected 1", keyHeld); end
    if (keyValid !== 1'b1) begin failures++; $display("[TB] FAIL overrun_second_valid: key_valid=%b expected 1", keyValid); end
    if (keyCode !== 4'd9) begin failures++; $display("[TB] FAIL overrun_second_code: key_code=%0d expected 9", keyCode); end
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_flag: overrun=%b expected 1", overrun); end
    keysDown[9] = 1'b0;
    waitHeldLow("overrun_second_release");
    ackPulse();
    checks += 3;
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL overrun_ack_valid: key_valid=%b expected 0", keyValid); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_ack_flag: overrun=%b expected 0", overrun); end
    if (keyCode !== 4'd9) begin failures++; $display("[TB] FAIL overrun_ack_code: key_code=%0d expected 9", keyCode); end
  endtask

  task automatic test_ack_collision();
    alignPass();
    keysDown[3] = 1'b1;
    waitValidHigh("collision_first_valid");
    checks++;
    if (keyCode !== 4'd3) begin failures++; $display("[TB] FAIL collision_first_code: key_code=%0d expected 3", keyCode); end
    keysDown[3] = 1'b0;
    waitHeldLow("collision_first_release");
    alignPass();
    keysDown[12] = 1'b1;
    step(31);
    checks += 2;
    if (keyHeld !== 1'b0) begin failures++; $display("[TB] FAIL collision_pre_held: key_held=%b expected 0", keyHeld); end
    if (keyValid !== 1'b1) begin failures++; $display("[TB] FAIL collision_pre_valid: key_valid=%b expected 1", keyValid); end
    ackPulse();
    checks += 4;
    if (keyValid !== 1'b1) begin failures++; $display("[TB] FAIL collision_valid: key_valid=%b expected 1", keyValid); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL collision_overrun: overrun=%b expected 0", overrun); end
    if (keyCode !== 4'd12) begin failures++; $display("[TB] FAIL collision_code: key_code=%0d expected 12", keyCode); end
    if (keyHeld !== 1'b1) begin failures++; $display("[TB] FAIL collision_held: key_held=%b expected 1", keyHeld); end
    step(3);
    checks++;
    if (keyValid !== 1'b1) begin failures++; $display("[TB] FAIL collision_sticky: key_valid=%b expected 1", keyValid); end
    keysDown[12] = 1'b0;
    waitHeldLow("collision_release");
  endtask

  task automatic test_reset_mid_debounce();
    alignPass();
    keysDown[6] = 1'b1;
    step(16);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (col !== 4'b1110) begin failures++; $display("[TB] FAIL midreset_col: col=%b expected 1110", col); end
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid: key_valid=%b expected 0", keyValid); end
    if (keyHeld !== 1'b0) begin failures++; $display("[TB] FAIL midreset_held: key_held=%b expected 0", keyHeld); end
    if (keyCode !== 4'd0) begin failures++; $display("[TB] FAIL midreset_code: key_code=%0d expected 0", keyCode); end
    step(3);
    rst_n = 1'b1;
    step(31);
    checks++;
    if (keyValid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_early_valid: key_valid=%b expected 0", keyValid); end
    step(1);
    checks += 2;
    if (keyValid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_valid_after: key_valid=%b expected 1", keyValid); end
    if (keyCode !== 4'd6) begin failures++; $display("[TB] FAIL midreset_code_after: key_code=%0d expected 6", keyCode); end
    keysDown[6] = 1'b0;
    waitHeldLow("midreset_release");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    keysDown = 16'h0000;
    keyAck   = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overrun();
    test_ack_collision();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
